// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vend_pkg
// Description : Shared types, coin codes and coin valuation for the
//               newspaper vending controller.
// Revision    : 1.0 - initial release
// ============================================================================
package vend_pkg;

   // Top-level controller states
   typedef enum logic [1:0] {
      ACCUM     = 2'd0,
      VEND      = 2'd1,
      CHANGE_HI = 2'd2,
      CHANGE_LO = 2'd3
   } state_t;

   // Change dispenser pulse phases
   typedef enum logic [1:0] {
      PH_IDLE = 2'd0,
      PH_HI   = 2'd1,
      PH_LO   = 2'd2
   } phase_t;

   // Coin codes as presented on the coin bus
   localparam logic [1:0] COIN_NONE    = 2'd0;
   localparam logic [1:0] COIN_NICKEL  = 2'd1;
   localparam logic [1:0] COIN_DIME    = 2'd2;
   localparam logic [1:0] COIN_QUARTER = 2'd3;

   // Value of a coin code in nickel units
   function automatic logic [2:0] coin_value(input logic [1:0] code);
      logic [2:0] v;
      case (code)
         COIN_NICKEL:  v = 3'd1;
         COIN_DIME:    v = 3'd2;
         COIN_QUARTER: v = 3'd5;
         default:      v = 3'd0;
      endcase
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vend_if.sv
`default_nettype none
// ============================================================================
// Module      : vend_if
// Description : Coin/cancel/dispense bundle between the vending datapath
//               and the sequencing controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface vend_if #(
   parameter int CREDIT_W = 4
);
   logic [1:0]          coin;
   logic                cancel;
   logic                vend_ack;
   logic                vend_req;
   logic                change_pulse;
   logic                coin_reject;
   logic [CREDIT_W-1:0] credit;
   logic                busy;

   // Datapath / stimulus side
   modport master (
      output coin, cancel, vend_ack,
      input  vend_req, change_pulse, coin_reject, credit, busy
   );

   // Controller side
   modport slave (
      input  coin, cancel, vend_ack,
      output vend_req, change_pulse, coin_reject, credit, busy
   );
endinterface
`default_nettype wire

// File: rtl/vend_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : change_dispenser
// Description : Paces change return as one-nickel pulses: one cycle high,
//               one cycle low, repeated while credit remains.
// Revision    : 1.0 - initial release
// ============================================================================
module change_dispenser #(
   parameter int CREDIT_W = 4
) (
   input  wire logic                clock,
   input  wire logic                reset,
   input  wire logic                load,   // start a change train
   input  wire logic [CREDIT_W-1:0] count,  // credit still owed
   output logic                     pulse,  // registered change pulse
   output logic                     step,   // credit is decremented this edge
   output logic                     done    // train finished this edge
);
   import vend_pkg::*;

   phase_t r_phase;
   phase_t w_phase_nxt;
   logic   r_pulse;

   // Next-phase decode: HI always falls to LO; LO re-arms while credit remains
   always_comb begin
      w_phase_nxt = r_phase;
      case (r_phase)
         PH_IDLE: if (load) w_phase_nxt = PH_HI;
         PH_HI:   w_phase_nxt = PH_LO;
         PH_LO:   w_phase_nxt = (count != '0) ? PH_HI : PH_IDLE;
         default: w_phase_nxt = PH_IDLE;
      endcase
   end

   // Phase register; the pulse is registered so it lines up with PH_HI
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_phase <= PH_IDLE;
         r_pulse <= 1'b0;
      end else begin
         r_phase <= w_phase_nxt;
         r_pulse <= (w_phase_nxt == PH_HI);
      end
   end

   assign pulse = r_pulse;
   assign step  = (r_phase == PH_HI);
   assign done  = (r_phase == PH_LO) && (count == '0);

endmodule
`default_nettype wire

// File: rtl/vend_controller.sv
`default_nettype none
// ============================================================================
// Module      : vend_controller
// Description : Accumulates coin credit against a price, requests a vend
//               over req/ack and returns surplus or refunded credit as
//               nickel change pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module vend_controller #(
   parameter int PRICE      = 3,
   parameter int CREDIT_W   = 4,
   parameter int MAX_CREDIT = 2**CREDIT_W-1
) (
   input  wire logic clock,
   input  wire logic reset,
   vend_if.slave     bus
);
   import vend_pkg::*;

   localparam logic [CREDIT_W:0]   c_max_x   = (CREDIT_W+1)'(MAX_CREDIT);
   localparam logic [CREDIT_W:0]   c_price_x = (CREDIT_W+1)'(PRICE);
   localparam logic [CREDIT_W-1:0] c_price   = CREDIT_W'(PRICE);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CREDIT_W-1:0] r_credit;
   logic [CREDIT_W-1:0] w_credit_nxt;
   logic                r_reject;
   logic                w_reject_nxt;
   logic                r_vend_req;
   logic                r_busy;
   logic                w_load;
   logic                w_step;
   logic                w_done;
   logic                w_pulse;
   logic                w_coin_in;
   logic [CREDIT_W:0]   w_sum;
   logic [CREDIT_W-1:0] w_remain;

   // One extra bit on the sum so an overflowing coin is detected, not wrapped
   assign w_coin_in = (bus.coin != COIN_NONE);
   assign w_sum     = {1'b0, r_credit} + (CREDIT_W+1)'(coin_value(bus.coin));
   assign w_remain  = r_credit - c_price;

   change_dispenser #(
      .CREDIT_W (CREDIT_W)
   ) u_change (
      .clock (clock),
      .reset (reset),
      .load  (w_load),
      .count (r_credit),
      .pulse (w_pulse),
      .step  (w_step),
      .done  (w_done)
   );

   // Next-state, credit arithmetic and coin rejection
   always_comb begin
      w_state_nxt  = r_state;
      w_credit_nxt = r_credit;
      w_reject_nxt = 1'b0;
      w_load       = 1'b0;
      case (r_state)
         ACCUM: begin
            if (bus.cancel) begin
               // cancel takes priority; any coin alongside it is refused
               w_reject_nxt = w_coin_in;
               if (r_credit != '0) begin
                  w_state_nxt = CHANGE_HI;
                  w_load      = 1'b1;
               end
            end else if (w_coin_in) begin
               if (w_sum > c_max_x) begin
                  w_reject_nxt = 1'b1;
               end else begin
                  w_credit_nxt = w_sum[CREDIT_W-1:0];
                  if (w_sum >= c_price_x) w_state_nxt = VEND;
               end
            end
         end
         VEND: begin
            w_reject_nxt = w_coin_in;
            if (bus.vend_ack) begin
               w_credit_nxt = w_remain;
               if (w_remain != '0) begin
                  w_state_nxt = CHANGE_HI;
                  w_load      = 1'b1;
               end else begin
                  w_state_nxt = ACCUM;
               end
            end
         end
         CHANGE_HI: begin
            w_reject_nxt = w_coin_in;
            if (w_step) begin
               w_credit_nxt = r_credit - CREDIT_W'(1);
               w_state_nxt  = CHANGE_LO;
            end
         end
         CHANGE_LO: begin
            w_reject_nxt = w_coin_in;
            w_state_nxt  = w_done ? ACCUM : CHANGE_HI;
         end
         default: w_state_nxt = ACCUM;
      endcase
   end

   // State, credit and registered outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= ACCUM;
         r_credit   <= '0;
         r_reject   <= 1'b0;
         r_vend_req <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_credit   <= w_credit_nxt;
         r_reject   <= w_reject_nxt;
         r_vend_req <= (w_state_nxt == VEND);
         r_busy     <= (w_state_nxt != ACCUM);
      end
   end

   assign bus.vend_req     = r_vend_req;
   assign bus.change_pulse = w_pulse;
   assign bus.coin_reject  = r_reject;
   assign bus.credit       = r_credit;
   assign bus.busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_vend_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_vend_controller
// Description : Directed self-checking bench for vend_controller, with a
//               second instance at PRICE=15 for the overflow boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vend_controller;

   logic clock;
   logic reset;
   int   n_cmp;
   int   n_bad;

   vend_if #(.CREDIT_W(4)) vif   ();
   vend_if #(.CREDIT_W(4)) vif15 ();

   vend_controller #(
      .PRICE    (3),
      .CREDIT_W (4)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (vif.slave)
   );

   vend_controller #(
      .PRICE    (15),
      .CREDIT_W (4)
   ) dut15 (
      .clock (clock),
      .reset (reset),
      .bus   (vif15.slave)
   );

   // 10 ns clock, rising edges at 5, 15, 25 ...
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Full output snapshot of the PRICE=3 instance
   task automatic chk_all(input string tag, input int cr, input int req,
                          input int pul, input int rej, input int bsy);
      chk({tag, ".credit"}, int'(vif.credit), cr);
      chk({tag, ".vend_req"}, int'(vif.vend_req), req);
      chk({tag, ".change"}, int'(vif.change_pulse), pul);
      chk({tag, ".reject"}, int'(vif.coin_reject), rej);
      chk({tag, ".busy"}, int'(vif.busy), bsy);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b1;
      vif.coin = 2'd0;   vif.cancel = 1'b0;   vif.vend_ack = 1'b0;
      vif15.coin = 2'd0; vif15.cancel = 1'b0; vif15.vend_ack = 1'b0;
      tick();
      tick();
      chk_all("reset", 0, 0, 0, 0, 0);
      chk("reset15.credit", int'(vif15.credit), 0);
      reset = 1'b0;

      // Three nickels separated by idle cycles
      vif.coin = 2'd1; tick(); vif.coin = 2'd0;
      chk_all("n1", 1, 0, 0, 0, 0);
      tick(); tick();
      vif.coin = 2'd1; tick(); vif.coin = 2'd0;
      chk_all("n2", 2, 0, 0, 0, 0);
      tick(); tick();
      vif.coin = 2'd1; tick(); vif.coin = 2'd0;
      chk_all("n3", 3, 1, 0, 0, 1);
      tick();
      chk_all("n3.hold", 3, 1, 0, 0, 1);
      vif.vend_ack = 1'b1; tick(); vif.vend_ack = 1'b0;
      chk_all("n3.ack", 0, 0, 0, 0, 0);
      tick();
      chk_all("n3.after", 0, 0, 0, 0, 0);

      // Two dimes: vend leaves one nickel of change
      vif.coin = 2'd2; tick(); vif.coin = 2'd0;
      chk_all("d1", 2, 0, 0, 0, 0);
      vif.coin = 2'd2; tick(); vif.coin = 2'd0;
      chk_all("d2", 4, 1, 0, 0, 1);
      vif.vend_ack = 1'b1; tick(); vif.vend_ack = 1'b0;
      chk_all("d2.ack", 1, 0, 1, 0, 1);
      tick();
      chk_all("d2.lo", 0, 0, 0, 0, 1);
      tick();
      chk_all("d2.idle", 0, 0, 0, 0, 0);

      // Quarter: two change pulses two cycles apart
      vif.coin = 2'd3; tick(); vif.coin = 2'd0;
      chk_all("q", 5, 1, 0, 0, 1);
      vif.vend_ack = 1'b1; tick(); vif.vend_ack = 1'b0;
      chk_all("q.hi1", 2, 0, 1, 0, 1);
      tick();
      chk_all("q.lo1", 1, 0, 0, 0, 1);
      tick();
      chk_all("q.hi2", 1, 0, 1, 0, 1);
      tick();
      chk_all("q.lo2", 0, 0, 0, 0, 1);
      tick();
      chk_all("q.idle", 0, 0, 0, 0, 0);

      // Nickel then cancel: single-nickel refund, no vend
      vif.coin = 2'd1; tick(); vif.coin = 2'd0;
      chk_all("c.n", 1, 0, 0, 0, 0);
      vif.cancel = 1'b1; tick(); vif.cancel = 1'b0;
      chk_all("c.hi", 1, 0, 1, 0, 1);
      tick();
      chk_all("c.lo", 0, 0, 0, 0, 1);
      tick();
      chk_all("c.idle", 0, 0, 0, 0, 0);

      // Cancel with a dime in the same cycle: dime refused, nickel refunded
      vif.coin = 2'd1; tick(); vif.coin = 2'd0;
      vif.cancel = 1'b1; vif.coin = 2'd2; tick();
      vif.cancel = 1'b0; vif.coin = 2'd0;
      chk_all("cc.hi", 1, 0, 1, 1, 1);
      tick();
      chk_all("cc.lo", 0, 0, 0, 0, 1);
      tick();
      chk_all("cc.idle", 0, 0, 0, 0, 0);

      // Coin and cancel during VEND while ack is held off
      vif.coin = 2'd2; tick();
      tick(); vif.coin = 2'd0;
      chk_all("v.enter", 4, 1, 0, 0, 1);
      tick();
      vif.coin = 2'd2; tick(); vif.coin = 2'd0;
      chk_all("v.coin", 4, 1, 0, 1, 1);
      vif.cancel = 1'b1; tick(); vif.cancel = 1'b0;
      chk_all("v.cancel", 4, 1, 0, 0, 1);
      tick(); tick();
      chk_all("v.wait", 4, 1, 0, 0, 1);
      vif.vend_ack = 1'b1; tick(); vif.vend_ack = 1'b0;
      chk_all("v.ack", 1, 0, 1, 0, 1);
      tick(); tick();
      chk_all("v.idle", 0, 0, 0, 0, 0);

      // Ack outside VEND does nothing
      vif.vend_ack = 1'b1; tick(); vif.vend_ack = 1'b0;
      chk_all("stray.ack", 0, 0, 0, 0, 0);

      // Overflow at PRICE=15: 5+5+2 = 12, quarter would make 17
      vif15.coin = 2'd3; tick();
      tick();
      vif15.coin = 2'd2; tick(); vif15.coin = 2'd0;
      chk("o.credit12", int'(vif15.credit), 12);
      vif15.coin = 2'd3; tick(); vif15.coin = 2'd0;
      chk("o.reject", int'(vif15.coin_reject), 1);
      chk("o.hold", int'(vif15.credit), 12);
      chk("o.noreq", int'(vif15.vend_req), 0);
      vif15.coin = 2'd1; tick(); vif15.coin = 2'd0;
      chk("o.credit13", int'(vif15.credit), 13);
      chk("o.rej_clr", int'(vif15.coin_reject), 0);
      vif15.coin = 2'd2; tick(); vif15.coin = 2'd0;
      chk("o.max", int'(vif15.credit), 15);
      chk("o.req", int'(vif15.vend_req), 1);
      vif15.vend_ack = 1'b1; tick(); vif15.vend_ack = 1'b0;
      chk("o.ack.credit", int'(vif15.credit), 0);
      chk("o.ack.busy", int'(vif15.busy), 0);

      // Reset asserted between edges while in CHANGE_HI
      vif.coin = 2'd3; tick(); vif.coin = 2'd0;
      vif.vend_ack = 1'b1; tick(); vif.vend_ack = 1'b0;
      chk_all("r.hi", 2, 0, 1, 0, 1);
      #3 reset = 1'b1;
      #1;
      chk_all("r.async", 0, 0, 0, 0, 0);
      tick();
      #2 reset = 1'b0;
      tick();
      chk_all("r.released", 0, 0, 0, 0, 0);
      vif.coin = 2'd2; tick(); vif.coin = 2'd0;
      chk_all("r.dime", 2, 0, 0, 0, 0);
      vif.coin = 2'd1; tick(); vif.coin = 2'd0;
      chk_all("r.vend", 3, 1, 0, 0, 1);
      vif.vend_ack = 1'b1; tick(); vif.vend_ack = 1'b0;
      chk_all("r.done", 0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
